pipeline_control: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives enable and flush for the PC and the four pipeline latches IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles four events: load-use stalls, instruction-fetch misses, data-memory waits and taken-branch squashes.
- Sequences the drain on halt, and guards data-memory waits with a timeout flag.
- Forwarding is handled separately; this block only inserts the bubbles that forwarding cannot cover.

---
 rtl/pipeline_control.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control
// Brief    : Stall/flush sequencer for the 5-stage pipeline. Optional
//            performance counters are enabled by defining PIPE_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_control #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             ex_memread,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_HALTING  = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    localparam logic [15:0] c_timeout = 16'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_wait_cnt;
    logic        r_mem_timeout;
    logic        w_load_use;
    logic        w_mem_stall;

    assign w_load_use = ex_memread && (ex_wsel != 5'd0) &&
                        ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    // Once waiting, only dhit releases the freeze; dmem_req is no longer consulted.
    assign w_mem_stall = (r_state == S_MEM_WAIT) ? !dhit : (dmem_req && !dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        halt_out     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_next_state = S_RUN;
            end
            S_RUN, S_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_next_state = S_MEM_WAIT;
                end else begin
                    w_next_state = S_RUN;
                    if (halt_mem) begin
                        ifid_en      = 1'b1;
                        idex_en      = 1'b1;
                        exmem_en     = 1'b1;
                        memwb_en     = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        w_next_state = S_HALTING;
                    end else if (branch_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (w_load_use) begin
                        // IF/ID is held, so a concurrent fetch miss is simply retried.
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
            end
            S_HALTING: begin
                ifid_en      = 1'b1;
                idex_en      = 1'b1;
                exmem_en     = 1'b1;
                memwb_en     = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_flush  = 1'b1;
                w_next_state = S_HALTED;
            end
            S_HALTED: begin
                halt_out = 1'b1;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    // Counter holds the number of frozen cycles so far, saturating at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else if ((r_state == S_RUN) && w_mem_stall) begin
            r_wait_cnt <= 16'd1;
        end else if ((r_state == S_MEM_WAIT) && w_mem_stall) begin
            if (r_wait_cnt < c_timeout) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (r_wait_cnt >= (c_timeout - 16'd1)) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic             w_run_like;
    logic             w_branch_sq;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    assign w_run_like  = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
    assign w_branch_sq = w_run_like && !w_mem_stall && !halt_mem && branch_taken;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_run_like && !pc_en) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_branch_sq) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control
// Brief    : Directed plus randomized bench for pipeline_control, checked
//            against a rule-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_control;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ihit = 1'b1, dhit = 1'b0, dmem_req = 1'b0, ex_memread = 1'b0;
    logic [4:0]  ex_wsel = '0, id_rs = '0, id_rt = '0;
    logic        id_uses_rt = 1'b0, branch_taken = 1'b0, halt_mem = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halt_out, mem_timeout;
    logic [31:0] stall_cycles, flush_count;

    pipeline_control #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt_out(halt_out), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ihit, dhit, dmem_req, ex_memread;
        logic [4:0] ex_wsel, id_rs, id_rt;
        logic       id_uses_rt, branch_taken, halt_mem;
    } stim_t;

    int npass  = 0;
    int ntotal = 0;

    // Reference model: pipeline life-cycle flags plus wait length and event tallies.
    bit          m_started, m_waiting, m_draining, m_halted, m_tmo;
    int          m_wlen;
    int unsigned m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] mask(input logic [7:0] v);
        return {v[7:3], v[2] & v[6], v[1] & v[5], v[0] & v[4]};
    endfunction

    function automatic logic [31:0] perf(input int unsigned v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return (v == 32'd0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.ihit = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd(input bit allow_halt);
        stim_t s;
        s.ihit         = ($urandom_range(0, 3) != 0);
        s.dhit         = ($urandom_range(0, 1) != 0);
        s.dmem_req     = ($urandom_range(0, 3) == 0);
        s.ex_memread   = ($urandom_range(0, 2) == 0);
        s.ex_wsel      = 5'($urandom_range(0, 5));
        s.id_rs        = 5'($urandom_range(0, 5));
        s.id_rt        = 5'($urandom_range(0, 5));
        s.id_uses_rt   = ($urandom_range(0, 1) != 0);
        s.branch_taken = ($urandom_range(0, 7) == 0);
        s.halt_mem     = allow_halt && ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    task automatic model_reset();
        m_started  = 0;
        m_waiting  = 0;
        m_draining = 0;
        m_halted   = 0;
        m_tmo      = 0;
        m_wlen     = 0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    task automatic tick(input stim_t s, input string tag);
        logic [7:0] e, o;
        bit ehalt, r3, mstall, gohalt, lu;
        @(negedge CLK);
        ihit = s.ihit; dhit = s.dhit; dmem_req = s.dmem_req; ex_memread = s.ex_memread;
        ex_wsel = s.ex_wsel; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
        branch_taken = s.branch_taken; halt_mem = s.halt_mem;
        #2;
        e = '0; ehalt = 0; r3 = 0; mstall = 0; gohalt = 0;
        lu = s.ex_memread && (s.ex_wsel != 0) &&
             ((s.ex_wsel == s.id_rs) || (s.id_uses_rt && (s.ex_wsel == s.id_rt)));
        if (!m_started) e = '0;
        else if (m_halted) ehalt = 1;
        else if (m_draining) e = 8'b0111_1111;
        else begin
            mstall = m_waiting ? !s.dhit : (s.dmem_req && !s.dhit);
            if (mstall) e = '0;
            else if (s.halt_mem) begin e = 8'b0111_1111; gohalt = 1; end
            else if (s.branch_taken) begin e = 8'b1111_1111; r3 = 1; end
            else if (lu) e = 8'b0011_1010;
            else if (!s.ihit) e = 8'b0111_1100;
            else e = 8'b1111_1000;
        end
        o = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
        chk({tag, " enables/flushes"}, {24'd0, mask(o)}, {24'd0, mask(e)});
        chk({tag, " halt_out"}, {31'd0, halt_out}, {31'd0, ehalt});
        chk({tag, " mem_timeout"}, {31'd0, mem_timeout}, {31'd0, m_tmo});
        chk({tag, " stall_cycles"}, stall_cycles, perf(m_stall));
        chk({tag, " flush_count"}, flush_count, perf(m_flush));
        if (m_started && !m_halted && !m_draining && !e[7]) m_stall++;
        if (r3) m_flush++;
        if (!m_started) m_started = 1;
        else if (m_halted) m_halted = 1;
        else if (m_draining) begin m_draining = 0; m_halted = 1; end
        else if (mstall) begin
            if (!m_waiting) begin m_waiting = 1; m_wlen = 1; end
            else begin m_wlen++; if (m_wlen >= T) m_tmo = 1; end
        end else begin
            m_waiting = 0;
            if (gohalt) m_draining = 1;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        #3 nRST = 1'b0;
        #1;
        model_reset();
        chk({tag, " rst enables"},
            {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush},
            32'd0);
        chk({tag, " rst halt_out"}, {31'd0, halt_out}, 32'd0);
        chk({tag, " rst mem_timeout"}, {31'd0, mem_timeout}, 32'd0);
        chk({tag, " rst stall_cycles"}, stall_cycles, 32'd0);
        chk({tag, " rst flush_count"}, flush_count, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        stim_t s;
        model_reset();
        do_reset("power-on");
        tick(idle(), "init cycle");
        tick(idle(), "first run");

        s = idle(); s.ex_memread = 1; s.ex_wsel = 5'd8; s.id_rs = 5'd8;
        tick(s, "load-use rs");
        tick(idle(), "after load-use");
        s = idle(); s.ex_memread = 1; s.ex_wsel = 5'd9; s.id_rs = 5'd3; s.id_rt = 5'd9; s.id_uses_rt = 1;
        tick(s, "load-use rt");
        s.id_uses_rt = 0;
        tick(s, "rt not used");
        s = idle(); s.ex_memread = 1; s.ex_wsel = 5'd0; s.id_rs = 5'd0;
        tick(s, "load to r0");
        s = idle(); s.ex_memread = 1; s.ex_wsel = 5'd8; s.id_rs = 5'd8; s.ihit = 0;
        tick(s, "load-use with imiss");
        s = idle(); s.ihit = 0;
        tick(s, "imiss");
        s = idle(); s.branch_taken = 1; s.ihit = 0;
        tick(s, "branch with imiss");
        s = idle(); s.dmem_req = 1; s.dhit = 1;
        tick(s, "dmem hit");

        s = idle(); s.dmem_req = 1;
        for (int i = 0; i < 5; i++) tick(s, "dmem wait");
        s.dhit = 1;
        tick(s, "dmem release");
        tick(idle(), "after dmem");

        for (int i = 0; i < 400; i++) tick(rnd(1'b0), "random");

        s = idle(); s.dmem_req = 1;
        for (int i = 0; i < 3; i++) tick(s, "wait before reset");
        do_reset("mid-wait");
        tick(idle(), "init after reset");
        tick(idle(), "run after reset");

        s = idle(); s.halt_mem = 1;
        tick(s, "halt in mem");
        tick(idle(), "halting");
        for (int i = 0; i < 20; i++) tick(rnd(1'b1), "halted");

        do_reset("after halt");
        tick(idle(), "init after halt");
        tick(idle(), "run after halt");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
